// File: rtl/floor_call_dispatch.sv
// Hall-call latch and SCAN target selection for one elevator car.
// Presents one pending floor to the door controller and retires it on door_done.
module floor_call_dispatch #(
   parameter logic [1:0] ST_FLOOR   = 2'b00,
   parameter logic [1:0] ND_FLOOR   = 2'b01,
   parameter logic [1:0] RD_FLOOR   = 2'b10,
   parameter int         GAP_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_st,
   input  logic       btn_nd,
   input  logic       btn_rd,
   input  logic [1:0] floor,
   input  logic       is_mooving,
   input  logic       door_done,
   output logic       st_led,
   output logic       nd_led,
   output logic       rd_led,
   output logic [1:0] open_when,
   output logic       call_valid,
   output logic       dir_up
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;

   // Floor index 0/1/2 (lowest to highest) back to its external encoding.
   function automatic logic [1:0] idx_to_floor(input logic [1:0] idx);
      logic [1:0] code;
      case (idx)
         2'd0:    code = ST_FLOOR;
         2'd1:    code = ND_FLOOR;
         2'd2:    code = RD_FLOOR;
         default: code = ST_FLOOR;
      endcase
      return code;
   endfunction

   logic [1:0] state_r, state_nxt_s;
   logic [2:0] btn_s, btn_q_r, press_s;
   logic [2:0] led_r, led_nxt_s;
   logic [1:0] open_when_r, open_when_nxt_s;
   logic       call_valid_r, call_valid_nxt_s;
   logic       dir_up_r, dir_up_nxt_s;
   logic [7:0] gap_cnt_r, gap_cnt_nxt_s;
   logic [1:0] tgt_idx_r, tgt_idx_nxt_s;
   logic       floor_ok_s;
   logic [1:0] cur_idx_s;
   logic [2:0] above_s, below_s;
   logic [1:0] near_above_s, near_below_s;
   logic [1:0] sel_idx_s;
   logic       sel_dir_s;
   logic       clear_s;

   assign btn_s   = {btn_rd, btn_nd, btn_st};
   assign press_s = btn_s & ~btn_q_r;

   // Decode car position into a floor index; unknown codes mean between floors.
   always_comb begin
      floor_ok_s = 1'b0;
      cur_idx_s  = 2'd0;
      if (floor == ST_FLOOR) begin
         floor_ok_s = 1'b1;
         cur_idx_s  = 2'd0;
      end else if (floor == ND_FLOOR) begin
         floor_ok_s = 1'b1;
         cur_idx_s  = 2'd1;
      end else if (floor == RD_FLOOR) begin
         floor_ok_s = 1'b1;
         cur_idx_s  = 2'd2;
      end else begin
         floor_ok_s = 1'b0;
         cur_idx_s  = 2'd0;
      end
   end

   // Split pending calls into those above and below the car.
   always_comb begin
      above_s = 3'b000;
      below_s = 3'b000;
      case (cur_idx_s)
         2'd0: begin
            above_s = {led_r[2], led_r[1], 1'b0};
            below_s = 3'b000;
         end
         2'd1: begin
            above_s = {led_r[2], 2'b00};
            below_s = {2'b00, led_r[0]};
         end
         2'd2: begin
            above_s = 3'b000;
            below_s = {1'b0, led_r[1], led_r[0]};
         end
         default: begin
            above_s = 3'b000;
            below_s = 3'b000;
         end
      endcase
      if (above_s[1]) begin
         near_above_s = 2'd1;
      end else begin
         near_above_s = 2'd2;
      end
      if (below_s[1]) begin
         near_below_s = 2'd1;
      end else begin
         near_below_s = 2'd0;
      end
   end

   // SCAN choice: current floor, then onward in the sweep, otherwise reverse.
   always_comb begin
      sel_idx_s = cur_idx_s;
      sel_dir_s = dir_up_r;
      if (led_r[cur_idx_s]) begin
         sel_idx_s = cur_idx_s;
         sel_dir_s = dir_up_r;
      end else if (dir_up_r && (|above_s)) begin
         sel_idx_s = near_above_s;
         sel_dir_s = 1'b1;
      end else if (|below_s) begin
         sel_idx_s = near_below_s;
         sel_dir_s = 1'b0;
      end else begin
         sel_idx_s = near_above_s;
         sel_dir_s = 1'b1;
      end
   end

   assign clear_s = (state_r == S_WAIT) && door_done && (floor == open_when_r);

   // Next-state logic; a retiring door_done overrides a same-cycle press on that floor.
   always_comb begin
      state_nxt_s      = state_r;
      led_nxt_s        = led_r | press_s;
      open_when_nxt_s  = open_when_r;
      call_valid_nxt_s = call_valid_r;
      dir_up_nxt_s     = dir_up_r;
      gap_cnt_nxt_s    = gap_cnt_r;
      tgt_idx_nxt_s    = tgt_idx_r;
      case (state_r)
         S_IDLE: begin
            if ((|led_r) && !is_mooving && floor_ok_s) begin
               tgt_idx_nxt_s    = sel_idx_s;
               open_when_nxt_s  = idx_to_floor(sel_idx_s);
               call_valid_nxt_s = 1'b1;
               dir_up_nxt_s     = sel_dir_s;
               state_nxt_s      = S_WAIT;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_WAIT: begin
            if (clear_s) begin
               led_nxt_s[tgt_idx_r] = 1'b0;
               call_valid_nxt_s     = 1'b0;
               gap_cnt_nxt_s        = 8'(GAP_CYCLES);
               state_nxt_s          = S_GAP;
            end else begin
               state_nxt_s = S_WAIT;
            end
         end
         S_GAP: begin
            if (gap_cnt_r == 8'd0) begin
               state_nxt_s = S_IDLE;
            end else begin
               gap_cnt_nxt_s = gap_cnt_r - 8'd1;
               state_nxt_s   = S_GAP;
            end
         end
         default: begin
            state_nxt_s      = S_IDLE;
            call_valid_nxt_s = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= S_IDLE;
         btn_q_r      <= 3'b000;
         led_r        <= 3'b000;
         open_when_r  <= ST_FLOOR;
         call_valid_r <= 1'b0;
         dir_up_r     <= 1'b1;
         gap_cnt_r    <= 8'd0;
         tgt_idx_r    <= 2'd0;
      end else begin
         state_r      <= state_nxt_s;
         btn_q_r      <= btn_s;
         led_r        <= led_nxt_s;
         open_when_r  <= open_when_nxt_s;
         call_valid_r <= call_valid_nxt_s;
         dir_up_r     <= dir_up_nxt_s;
         gap_cnt_r    <= gap_cnt_nxt_s;
         tgt_idx_r    <= tgt_idx_nxt_s;
      end
   end

   assign st_led     = led_r[0];
   assign nd_led     = led_r[1];
   assign rd_led     = led_r[2];
   assign open_when  = open_when_r;
   assign call_valid = call_valid_r;
   assign dir_up     = dir_up_r;

endmodule

// File: tb/tb_floor_call_dispatch.sv
// Directed bench for floor_call_dispatch: hand-computed expectations on each scenario.
module tb_floor_call_dispatch;

   localparam int GAP = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       btn_st, btn_nd, btn_rd;
   logic [1:0] floor;
   logic       is_mooving, door_done;
   logic       st_led, nd_led, rd_led;
   logic [1:0] open_when;
   logic       call_valid, dir_up;

   int n_cmp = 0;
   int n_err = 0;

   floor_call_dispatch #(
      .ST_FLOOR(2'b00), .ND_FLOOR(2'b01), .RD_FLOOR(2'b10), .GAP_CYCLES(GAP)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .btn_st(btn_st), .btn_nd(btn_nd), .btn_rd(btn_rd),
      .floor(floor), .is_mooving(is_mooving), .door_done(door_done),
      .st_led(st_led), .nd_led(nd_led), .rd_led(rd_led),
      .open_when(open_when), .call_valid(call_valid), .dir_up(dir_up)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Count cycles until call_valid rises; an expired budget is reported as a failure.
   task automatic wait_call(output int n);
      n = 0;
      while (!call_valid && n < 20) begin
         tick();
         n++;
      end
      if (n >= 20) check_val("call_timeout", {7'd0, call_valid}, 8'd1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   int n_wait;

   initial begin
      rst_n = 1'b0; btn_st = 1'b0; btn_nd = 1'b0; btn_rd = 1'b1;
      floor = 2'b00; is_mooving = 1'b1; door_done = 1'b0;

      // 1: reset with a held button, then release
      ticks(2);
      check_val("rst_leds", {5'd0, rd_led, nd_led, st_led}, 8'd0);
      check_val("rst_valid", {7'd0, call_valid}, 8'd0);
      check_val("rst_open", {6'd0, open_when}, 8'd0);
      check_val("rst_dir", {7'd0, dir_up}, 8'd1);
      rst_n = 1'b1;
      tick();
      check_val("rel_rd_led", {7'd0, rd_led}, 8'd1);
      btn_rd = 1'b0;
      do_reset();
      is_mooving = 1'b0;

      // 2: single call, retire, gap before the next dispatch
      btn_rd = 1'b1; tick(); btn_rd = 1'b0;
      check_val("t2_led", {7'd0, rd_led}, 8'd1);
      check_val("t2_valid0", {7'd0, call_valid}, 8'd0);
      tick();
      check_val("t2_valid1", {7'd0, call_valid}, 8'd1);
      check_val("t2_open", {6'd0, open_when}, 8'h2);
      floor = 2'b10;
      btn_st = 1'b1; tick(); btn_st = 1'b0;
      check_val("t2_hold", {7'd0, call_valid}, 8'd1);
      door_done = 1'b1; tick(); door_done = 1'b0;
      check_val("t2_clr", {7'd0, rd_led}, 8'd0);
      check_val("t2_drop", {7'd0, call_valid}, 8'd0);
      wait_call(n_wait);
      check_val("t2_gap", {7'd0, (n_wait >= GAP + 1)}, 8'd1);
      check_val("t2_next", {6'd0, open_when}, 8'h0);
      check_val("t2_dir", {7'd0, dir_up}, 8'd0);
      floor = 2'b00; door_done = 1'b1; tick(); door_done = 1'b0;
      check_val("t2_st_clr", {7'd0, st_led}, 8'd0);
      ticks(8);

      // 3: SCAN from floor 01 going up with calls at 00 and 10; moving blocks dispatch
      do_reset();
      is_mooving = 1'b1; floor = 2'b01;
      btn_st = 1'b1; btn_rd = 1'b1; tick(); btn_st = 1'b0; btn_rd = 1'b0;
      check_val("t3_multi", {5'd0, rd_led, nd_led, st_led}, 8'h5);
      ticks(3);
      check_val("t3_moving", {7'd0, call_valid}, 8'd0);
      is_mooving = 1'b0; tick();
      check_val("t3_valid", {7'd0, call_valid}, 8'd1);
      check_val("t3_open_up", {6'd0, open_when}, 8'h2);
      check_val("t3_dir_up", {7'd0, dir_up}, 8'd1);
      floor = 2'b10; door_done = 1'b1; tick(); door_done = 1'b0;
      check_val("t3_leds", {5'd0, rd_led, nd_led, st_led}, 8'h1);
      wait_call(n_wait);
      check_val("t3_open_dn", {6'd0, open_when}, 8'h0);
      check_val("t3_dir_dn", {7'd0, dir_up}, 8'd0);
      floor = 2'b00; door_done = 1'b1; tick(); door_done = 1'b0;
      ticks(8);

      // 4/5: reverse to up, misplaced door_done ignored, clear beats same-cycle press
      btn_rd = 1'b1; tick(); btn_rd = 1'b0; tick();
      check_val("t4_open", {6'd0, open_when}, 8'h2);
      check_val("t4_dir", {7'd0, dir_up}, 8'd1);
      floor = 2'b01; door_done = 1'b1; tick(); door_done = 1'b0;
      check_val("t5_ignored", {7'd0, call_valid}, 8'd1);
      check_val("t5_led_kept", {7'd0, rd_led}, 8'd1);
      floor = 2'b10; btn_rd = 1'b1; door_done = 1'b1; tick();
      btn_rd = 1'b0; door_done = 1'b0;
      check_val("t4_clr_wins", {7'd0, rd_led}, 8'd0);
      check_val("t4_drop", {7'd0, call_valid}, 8'd0);
      ticks(8);

      // 6: call at the current floor, then async reset mid-WAIT
      floor = 2'b01;
      btn_nd = 1'b1; tick(); btn_nd = 1'b0; tick();
      check_val("t6_here", {6'd0, open_when}, 8'h1);
      check_val("t6_valid", {7'd0, call_valid}, 8'd1);
      #2 rst_n = 1'b0;
      #1;
      check_val("t6_async_led", {5'd0, rd_led, nd_led, st_led}, 8'd0);
      check_val("t6_async_valid", {7'd0, call_valid}, 8'd0);
      check_val("t6_async_open", {6'd0, open_when}, 8'h0);
      check_val("t6_async_dir", {7'd0, dir_up}, 8'd1);
      tick();
      rst_n = 1'b1;
      ticks(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
